// File: rtl/sram_word_seq.sv
// Word-to-byte sequencer for the byte-wide SRAM port: splits 32-bit requests into
// setup/hold byte accesses and reassembles read words.
module sram_word_seq #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rw,
    input  logic [18:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic [20:0] o_sram_addr,
    output logic        o_sram_rw,
    output logic [7:0]  o_sram_wdata,
    input  logic [7:0]  i_sram_rdata,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request transfers on a rising edge where i_req_valid and o_req_ready
    // are both high; o_req_ready is high only while idle, so one request is in flight.

    typedef enum logic [1:0] {IDLE, SETUP, HOLD, DONE} state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

    state_t      state, state_nxt;
    logic        cap_rw;
    logic [18:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  pend;
    logic [1:0]  cur_k;
    logic [3:0]  hold_cnt;
    logic [31:0] rd_acc;

    logic        accept;
    logic        hold_last;
    logic [3:0]  req_mask;
    logic [3:0]  src_mask;
    logic [1:0]  next_k;
    logic [18:0] src_addr;
    logic [31:0] src_wdata;
    logic [31:0] rd_merged;

    function automatic logic [1:0] first_byte(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    assign accept    = (state == IDLE) && i_req_valid && o_req_ready;
    assign hold_last = (state == HOLD) && (hold_cnt == 4'd1);
    assign req_mask  = i_req_rw ? 4'b1111 : i_req_be;
    // Byte selection comes from the live request when leaving IDLE, else from the
    // bytes still pending for the captured request.
    assign src_mask  = (state == IDLE) ? req_mask    : pend;
    assign src_addr  = (state == IDLE) ? i_req_addr  : cap_addr;
    assign src_wdata = (state == IDLE) ? i_req_wdata : cap_wdata;
    assign next_k    = first_byte(src_mask);
    assign o_dbg_state = state;

    always_comb begin
        rd_merged = rd_acc;
        case (cur_k)
            2'd0:    rd_merged[7:0]   = i_sram_rdata;
            2'd1:    rd_merged[15:8]  = i_sram_rdata;
            2'd2:    rd_merged[23:16] = i_sram_rdata;
            default: rd_merged[31:24] = i_sram_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (req_mask == 4'b0000) ? DONE : SETUP;
            end
            SETUP: state_nxt = HOLD;
            HOLD: begin
                if (hold_cnt == 4'd1) state_nxt = (pend == 4'b0000) ? DONE : SETUP;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_rw       <= 1'b1;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            pend         <= '0;
            cur_k        <= '0;
            hold_cnt     <= '0;
            rd_acc       <= '0;
            o_req_ready  <= 1'b1;
            o_rsp_valid  <= 1'b0;
            o_rsp_rdata  <= '0;
            o_sram_addr  <= '0;
            o_sram_rw    <= 1'b1;
            o_sram_wdata <= '0;
        end else begin
            if (accept) begin
                cap_rw    <= i_req_rw;
                cap_addr  <= i_req_addr;
                cap_wdata <= i_req_wdata;
                pend      <= req_mask & (req_mask - 4'd1);
            end
            if (state_nxt == SETUP) begin
                cur_k        <= next_k;
                pend         <= src_mask & (src_mask - 4'd1);
                o_sram_addr  <= {src_addr, next_k};
                o_sram_wdata <= byte_of(src_wdata, next_k);
            end
            if (state == SETUP)     hold_cnt <= HOLD_LOAD;
            else if (state == HOLD) hold_cnt <= hold_cnt - 4'd1;
            if (hold_last && cap_rw) begin
                rd_acc <= rd_merged;
                if (pend == 4'b0000) o_rsp_rdata <= rd_merged;
            end
            o_req_ready <= (state_nxt == IDLE);
            o_rsp_valid <= (state_nxt == DONE);
            // Strobe low only through HOLD of a write; every SETUP re-raises it.
            o_sram_rw   <= !((state_nxt == HOLD) && !cap_rw);
        end
    end

endmodule

// File: doc/sram_word_seq.md
Name: sram_word_seq

Overview:
- Word-level front end for the byte-wide SRAM port block.
- Accepts 32-bit read/write requests over a valid/ready handshake and splits each one into up to four sequenced byte accesses.
- Drives the byte-port address, rw and write-data lines with setup and hold timing.
- Collects the read bytes back into a 32-bit word and returns it with a one-cycle response pulse.
- Sits between the application logic (frame/pixel engines) and the SRAM byte port.

Parameters:
- HOLD_CYCLES, 2: cycles each byte access is held after its setup cycle; legal range 1..15.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  block idle, can accept a request
- i_req_rw  in  1  1 = read, 0 = write
- i_req_addr  in  19  word address
- i_req_wdata  in  32  write data; byte k = bits [8k+7:8k]
- i_req_be  in  4  write byte enables, active-high; ignored for reads
- o_rsp_valid  out  1  one-cycle completion pulse, for both reads and writes
- o_rsp_rdata  out  32  assembled read word
- o_sram_addr  out  21  byte address to the SRAM port
- o_sram_rw  out  1  1 = read, 0 = write strobe
- o_sram_wdata  out  8  byte to write
- i_sram_rdata  in  8  byte read from the SRAM port

Behaviour:
- Clocking and reset:
  - Single clock domain, i_clk.
  - Reset is asynchronous, active-low (i_rst_n).
  - All outputs are registered.
- Reset values:
  - o_req_ready = 1
  - o_rsp_valid = 0
  - o_rsp_rdata = 0
  - o_sram_addr = 0
  - o_sram_rw = 1
  - o_sram_wdata = 0
  - FSM in IDLE.
- FSM states: IDLE, SETUP, HOLD, DONE.
- IDLE:
  - o_req_ready = 1 and o_sram_rw = 1.
  - On an edge with i_req_valid & o_req_ready, capture rw, addr, wdata and be, and drop ready.
  - Build the byte list: reads cover bytes 0..3; writes cover only the k with be[k] = 1, in ascending k.
  - Empty list (write with be = 0000): go to DONE; no SRAM activity.
  - Otherwise go to SETUP with the first byte in the list.
- SETUP (exactly 1 cycle):
  - o_sram_addr = {addr, k[1:0]}, o_sram_wdata = wdata byte k, o_sram_rw = 1.
  - Then go to HOLD with the hold counter loaded.
- HOLD (HOLD_CYCLES cycles):
  - Address and wdata stay stable.
  - o_sram_rw = 0 for a write, 1 for a read.
  - On the last HOLD cycle of a read, sample i_sram_rdata into rdata byte k.
  - After the last HOLD cycle: go to SETUP for the next listed byte, or to DONE if none remain.
  - o_sram_rw returns to 1 in every SETUP cycle, so each write strobe is a separate pulse.
- DONE (1 cycle):
  - o_rsp_valid = 1, o_sram_rw = 1.
  - For reads, o_rsp_rdata takes the assembled word in this cycle.
  - For writes, o_rsp_rdata keeps its previous value.
  - Next state is IDLE; o_req_ready rises in the cycle after DONE.
- Latency:
  - N = number of listed bytes.
  - o_rsp_valid is high in cycle N*(HOLD_CYCLES+1)+1 after the accepting edge.
  - Full read with HOLD_CYCLES = 2: response in cycle 13; next accept is possible at the edge ending cycle 14.
- Back-to-back: i_req_valid held high is accepted on the first IDLE cycle; there is never more than one request in flight.
- Requests while busy: ready is low, the request is not captured, and the requester holds its inputs.
- Inputs changing during an access: ignored; the captured copies are used.
- Reset mid-operation:
  - All state clears immediately.
  - o_sram_rw goes to 1 asynchronously, aborting any write strobe.
  - No o_rsp_valid is issued for the aborted request.
- Address wrap: none; the byte address is formed by concatenation only, and word addresses cover the full 19 bits.

Test Plan:
- Reset release, then a read at addr 0x00010 with HOLD_CYCLES = 2 and SRAM model bytes 0x11,0x22,0x33,0x44 at 0x40..0x43 -> o_sram_addr steps 0x40..0x43, each held 3 cycles; o_rsp_valid pulses in cycle 13; o_rsp_rdata = 0x44332211.
- Write addr 0x7FFFF, wdata 0xDEADBEEF, be 1111 -> four rw = 0 pulses of 2 cycles each, each preceded by an rw = 1 setup cycle, at 0x1FFFFC..0x1FFFFF with bytes EF,BE,AD,DE; rsp in cycle 13; rdata unchanged.
- Write be 0101, wdata 0xAABBCCDD -> only bytes 0 (DD) and 2 (BB) are accessed; rsp in cycle 7; read-back returns model bytes 1 and 3 untouched.
- Write be 0000 -> no rw = 0 ever; o_rsp_valid in cycle 1; ready back in cycle 2.
- i_req_valid held high with two queued reads -> second accepted exactly 1 cycle after the first response; ready is never high while FSM is busy.
- i_rst_n pulled low during the HOLD of byte 1 of a write -> o_sram_rw = 1 immediately, no o_rsp_valid; after release, ready = 1 and a new read completes normally.
